// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default framing, line levels.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int STOP_BITS_DEF = 1;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } tx_state_e;

    // Frame length in bit periods; shared with the receiver side.
    function automatic int frame_len(input int data_bits, input int stop_bits);
        return 1 + data_bits + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Payload shift register (LSB out first) plus the per-state bit-period counter.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CW        = $clog2(DATA_BITS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 shift_i,
    input  logic                 cnt_clr_i,
    input  logic                 cnt_inc_i,
    input  logic [CW-1:0]        cnt_last_i,
    output logic                 bit_o,
    output logic                 cnt_done_o
);

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (shift_i) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
    end

    // Clear wins so a state entry always starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o      = shift_q[0];
    assign cnt_done_o = (cnt_q == cnt_last_i);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: valid/ready byte in, start/data/[parity]/stop out.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic                 inClock,
    input  logic                 reset,
    input  logic                 baudTick,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 txLine,
    output logic                 txBusy,
    output logic                 txDone,
    output tx_state_e            txState
);

    localparam int CW = $clog2(DATA_BITS + 1);

    // Handshake: a byte is taken on a rising inClock edge where txValid and
    // txReady are both high; txReady is high only in IDLE, txData is ignored
    // at all other times.

    tx_state_e state_q, state_d;
    logic      line_q, line_d;
    logic      done_q, done_d;
    logic      accept;
    logic      load, shift, cnt_clr, cnt_inc;
    logic      cur_bit, cnt_done;
    logic [CW-1:0] cnt_last;

    assign accept = txValid && (state_q == ST_IDLE);

    uart_tx_shifter #(
        .DATA_BITS (DATA_BITS),
        .CW        (CW)
    ) u_shifter (
        .clk_i      (inClock),
        .rst_i      (reset),
        .load_i     (load),
        .data_i     (txData),
        .shift_i    (shift),
        .cnt_clr_i  (cnt_clr),
        .cnt_inc_i  (cnt_inc),
        .cnt_last_i (cnt_last),
        .bit_o      (cur_bit),
        .cnt_done_o (cnt_done)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^txData;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_last = (state_q == ST_STOP) ? CW'(STOP_BITS - 1) : CW'(DATA_BITS - 1);
        case (state_q)
            ST_IDLE: begin
                line_d = IDLE_LEVEL;
                // Ticks are not looked at here, so a tick coincident with
                // accept cannot shorten the start bit.
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (baudTick) begin
                    state_d = ST_START;
                    line_d  = START_LEVEL;
                end
            end
            ST_START: begin
                if (baudTick) begin
                    state_d = ST_DATA;
                    line_d  = cur_bit;
                    shift   = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (baudTick) begin
                    if (cnt_done) begin
                        cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        line_d  = parity_q;
`else
                        state_d = ST_STOP;
                        line_d  = IDLE_LEVEL;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                        line_d  = cur_bit;
                        shift   = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baudTick) begin
                    state_d = ST_STOP;
                    line_d  = IDLE_LEVEL;
                    cnt_clr = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baudTick) begin
                    if (cnt_done) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        line_d  = IDLE_LEVEL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign txReady = (state_q == ST_IDLE);
    assign txBusy  = (state_q != ST_IDLE);
    assign txLine  = line_q;
    assign txDone  = done_q;
    assign txState = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 1-stop and 2-stop instances, tick every 16 clocks.
module tb_uart_tx_framer;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N1 = 1 + 8 + PAR + 1;
    localparam int N2 = 1 + 8 + PAR + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tick_cnt = 4'd0;
    logic       baudTick;
    int         cyc = 0;

    logic [7:0] data1 = 8'h00, data2 = 8'h00;
    logic       valid1 = 1'b0, valid2 = 1'b0;
    logic       ready1, line1, busy1, done1;
    logic       ready2, line2, busy2, done2;
    tx_state_e  st1, st2;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset / tick ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 4'd1;
        cyc      <= cyc + 1;
    end

    assign baudTick = (tick_cnt == 4'd15);

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .inClock (clk),
        .reset   (reset),
        .baudTick(baudTick),
        .txData  (data1),
        .txValid (valid1),
        .txReady (ready1),
        .txLine  (line1),
        .txBusy  (busy1),
        .txDone  (done1),
        .txState (st1)
    );

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .inClock (clk),
        .reset   (reset),
        .baudTick(baudTick),
        .txData  (data2),
        .txValid (valid2),
        .txReady (ready2),
        .txLine  (line2),
        .txBusy  (busy2),
        .txDone  (done2),
        .txState (st2)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 0) ? line1 : line2;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel == 0) ? ready1 : ready2;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy1 : busy2;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done1 : done2;
    endfunction

    // Expected line level per bit period: start, LSB-first data, parity, stops (rest 1).
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] b;
        b = 16'hFFFF;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        if (PAR == 1) b[9] = ^d;
        return b;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input int sel, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        if (sel == 0) begin valid1 = 1'b1; data1 = d; end
        else begin valid2 = 1'b1; data2 = d; end
        while (!ready_of(sel) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) check("send_ready_timeout", 1, 0);
        @(negedge clk);
        if (sel == 0) valid1 = 1'b0; else valid2 = 1'b0;
    endtask

    // Waits for the start edge, then checks every cycle of an n-period frame.
    task automatic capture(input int sel, input logic [15:0] bits, input int n,
                           input string tag, output int fall_cyc);
        int   wait_n, bad_line, bad_hs, done_n, bad_done;
        logic exp_line;
        wait_n = 0; bad_line = 0; bad_hs = 0; done_n = 0; bad_done = 0;
        while (line_of(sel) !== 1'b0 && wait_n < 400) begin @(negedge clk); wait_n++; end
        fall_cyc = cyc;
        if (wait_n >= 400) begin
            check({tag, "_start_timeout"}, 1, 0);
            return;
        end
        for (int j = 0; j <= 16 * n + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (j <= 16 * n) begin
                exp_line = (j < 16 * n) ? bits[j/16] : 1'b1;
                if (line_of(sel) !== exp_line) bad_line++;
                if (ready_of(sel) !== (j == 16 * n)) bad_hs++;
                if (busy_of(sel) !== (j < 16 * n)) bad_hs++;
                if (j % 16 == 8)
                    check($sformatf("%s_p%0d", tag, j / 16), {31'd0, line_of(sel)}, {31'd0, bits[j/16]});
            end
            if (done_of(sel) === 1'b1) begin
                done_n++;
                if (j != 16 * n) bad_done++;
            end
        end
        check({tag, "_shape"}, bad_line, 0);
        check({tag, "_rdy_busy"}, bad_hs, 0);
        check({tag, "_done_cnt"}, done_n, 1);
        check({tag, "_done_pos"}, bad_done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f1, f2, acc, n, bad, done_seen;

        repeat (3) @(negedge clk);
        check("rst_line1", {31'd0, line1}, 1);
        check("rst_ready1", {31'd0, ready1}, 1);
        check("rst_busy1", {31'd0, busy1}, 0);
        check("rst_done1", {31'd0, done1}, 0);
        check("rst_state1", 32'(st1), 32'(ST_IDLE));
        check("rst_line2", {31'd0, line2}, 1);
        reset = 1'b0;

        // Idle with ticks running: line must stay high, no handshake activity.
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (line1 !== 1'b1 || ready1 !== 1'b1 || done1 !== 1'b0) bad++;
        end
        check("idle_ticks", bad, 0);

        // Single bytes.
        fork
            send(0, 8'hA5);
            capture(0, frame_bits(8'hA5), N1, "a5", f1);
        join
        fork
            send(0, 8'h07);
            capture(0, frame_bits(8'h07), N1, "x07", f1);
        join

        // Accept on the same edge as a tick: start must wait a full period.
        n = 0;
        @(negedge clk);
        while (!baudTick && n < 40) begin @(negedge clk); n++; end
        valid1 = 1'b1;
        data1  = 8'hA5;
        acc    = cyc;
        fork
            capture(0, frame_bits(8'hA5), N1, "coinc", f1);
            begin @(negedge clk); valid1 = 1'b0; end
        join
        // Tick edge accepts; next tick is 16 edges later, seen at the following negedge.
        check("coinc_delay", f1 - acc, 17);

        // Back-to-back with txValid held high.
        fork
            begin
                n = 0;
                @(negedge clk);
                valid1 = 1'b1;
                data1  = 8'h55;
                while (!ready1 && n < 400) begin @(negedge clk); n++; end
                @(negedge clk);
                data1 = 8'hAA;
                @(negedge clk);
                while (!ready1 && n < 400) begin @(negedge clk); n++; end
                @(negedge clk);
                valid1 = 1'b0;
                if (n >= 400) check("b2b_drv_timeout", 1, 0);
            end
            begin
                capture(0, frame_bits(8'h55), N1, "b2b_55", f1);
                capture(0, frame_bits(8'hAA), N1, "b2b_aa", f2);
            end
        join
        check("b2b_gap", f2 - f1, 16 * (N1 + 1));

        // Reset in the middle of data bit 3.
        done_seen = 0;
        fork
            send(0, 8'hA5);
            begin
                n = 0;
                while (line1 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
                check("rst_mid_start", n < 400, 1);
                repeat (16 * 4 + 8) begin
                    @(negedge clk);
                    if (done1 === 1'b1) done_seen++;
                end
                reset = 1'b1;
                #1;
                check("rst_mid_line", {31'd0, line1}, 1);
                check("rst_mid_ready", {31'd0, ready1}, 1);
                check("rst_mid_busy", {31'd0, busy1}, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (done1 === 1'b1) done_seen++;
                end
                reset = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (done1 === 1'b1 || line1 !== 1'b1) done_seen++;
                end
            end
        join
        check("rst_mid_no_done", done_seen, 0);

        fork
            send(0, 8'h3C);
            capture(0, frame_bits(8'h3C), N1, "x3c", f1);
        join

        // Two stop bits.
        fork
            send(1, 8'hFF);
            capture(1, frame_bits(8'hFF), N2, "stop2", f1);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
